// File: rtl/aes_rkey_sequencer.sv
// Round-key store for the AES decryption engine: holds rk[0..Nr] and hands
// them out in inverse order, one per engine consume pulse, for every block.
module aes_rkey_sequencer #(
  parameter int KW     = 128,
  parameter int NK_MAX = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [3:0]    wr_addr,
  input  logic [0:KW-1] wr_data,
  input  logic          key_commit,
  input  logic [1:0]    klen_in,
  input  logic          key_clear,
  output logic [0:KW-1] rkey,
  output logic          rkey_vld,
  input  logic          next_rkey,
  output logic [1:0]    klen_sel,
  output logic          blk_done,
  output logic [15:0]   blk_cnt,
  output logic          cfg_err
);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_READY  = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

  state_e        state_q;
  logic [3:0]    ptr_q;
  logic [3:0]    nr_q;
  logic [1:0]    klen_q;
  logic          vld_q;
  logic          blk_done_q;
  logic [15:0]   blk_cnt_q;
  logic          cfg_err_q;
  logic [0:KW-1] key_q [NK_MAX];

  logic [3:0]    nr_d;
  logic          klen_ok;
  logic          addr_ok;
  logic          key_we;

  always_comb begin
    nr_d = 4'd10;
    case (klen_in)
      2'b01:   nr_d = 4'd12;
      2'b10:   nr_d = 4'd14;
      default: nr_d = 4'd10;
    endcase
  end

  assign klen_ok = (klen_in != 2'b11);
  assign addr_ok = (wr_addr != 4'd15);

  // Keys are frozen while a block streams; a clear also wins over a write.
  assign key_we = wr_en && addr_ok && !key_clear && (state_q != ST_STREAM);

  always_ff @(posedge clk) begin
    if (key_we) begin
      key_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOAD;
      ptr_q      <= 4'd0;
      nr_q       <= 4'd10;
      klen_q     <= 2'b00;
      vld_q      <= 1'b0;
      blk_done_q <= 1'b0;
      blk_cnt_q  <= 16'd0;
      cfg_err_q  <= 1'b0;
    end else begin
      blk_done_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      if (key_clear) begin
        state_q <= ST_LOAD;
        ptr_q   <= 4'd0;
        vld_q   <= 1'b0;
      end else begin
        if (wr_en && !addr_ok) begin
          cfg_err_q <= 1'b1;
        end
        case (state_q)
          ST_LOAD: begin
            if (key_commit) begin
              if (klen_ok) begin
                klen_q  <= klen_in;
                nr_q    <= nr_d;
                ptr_q   <= nr_d;
                vld_q   <= 1'b1;
                state_q <= ST_READY;
              end else begin
                cfg_err_q <= 1'b1;
              end
            end
          end
          ST_READY: begin
            // A commit re-arms with whatever the write in this cycle left behind.
            if (key_commit) begin
              if (klen_ok) begin
                klen_q <= klen_in;
                nr_q   <= nr_d;
                ptr_q  <= nr_d;
              end else begin
                cfg_err_q <= 1'b1;
              end
            end else if (wr_en && addr_ok) begin
              state_q <= ST_LOAD;
              ptr_q   <= 4'd0;
              vld_q   <= 1'b0;
            end else if (next_rkey) begin
              ptr_q   <= nr_q - 4'd1;
              state_q <= ST_STREAM;
            end
          end
          ST_STREAM: begin
            if (wr_en || key_commit) begin
              cfg_err_q <= 1'b1;
            end
            if (next_rkey) begin
              if (ptr_q == 4'd0) begin
                ptr_q      <= nr_q;
                state_q    <= ST_READY;
                blk_done_q <= 1'b1;
                blk_cnt_q  <= blk_cnt_q + 16'd1;
              end else begin
                ptr_q <= ptr_q - 4'd1;
              end
            end
          end
          default: begin
            state_q <= ST_LOAD;
            ptr_q   <= 4'd0;
            vld_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rkey     = key_q[ptr_q];
  assign rkey_vld = vld_q;
  assign klen_sel = klen_q;
  assign blk_done = blk_done_q;
  assign blk_cnt  = blk_cnt_q;
  assign cfg_err  = cfg_err_q;

endmodule

// File: doc/aes_rkey_sequencer.md
Name: aes_rkey_sequencer

Overview:
- Round-key store and sequencer that feeds the AES decryption engine.
- Host writes the forward-expanded round keys rk[0..Nr] and commits them. The block then presents them in inverse order (rk[Nr] first, rk[0] last), one key per engine consume pulse, for every ciphertext block.
- Drives the engine's klen_sel from a latched copy, so key length cannot change mid-block.

Parameters:
- KW, 128, round-key width in bits.
- NK_MAX, 15, key storage depth (Nr max 14, so 15 keys).

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- wr_en  in  1  write round key wr_data into slot wr_addr.
- wr_addr  in  4  slot index 0..14; 15 is ignored.
- wr_data  in  KW  round key, bit 0 = MSB.
- key_commit  in  1  pulse: key set complete, using klen_in.
- klen_in  in  2  00 = AES-128 (Nr=10), 01 = AES-192 (Nr=12), 10 = AES-256 (Nr=14), 11 = invalid.
- key_clear  in  1  pulse: invalidate the key set and abort any block.
- rkey  out  KW  current round key to the engine.
- rkey_vld  out  1  rkey valid.
- next_rkey  in  1  engine consume strobe.
- klen_sel  out  2  latched key length to the engine.
- blk_done  out  1  one-cycle pulse when rk[0] is consumed.
- blk_cnt  out  16  completed-block counter; wraps.
- cfg_err  out  1  one-cycle pulse on a rejected write or commit.

Behaviour:
- Reset (async assert, sync deassert): state=LOAD, ptr=0, klen_sel=00, rkey_vld=0, blk_done=0, blk_cnt=0, cfg_err=0. Key RAM contents are not reset.
- Key storage: 15 x KW register array. rkey = key[ptr], a combinational mux of the registered ptr, so a new key is available the cycle after each consume.
- State LOAD: rkey_vld=0, writes accepted, next_rkey ignored.
  - key_commit with klen_in != 11: klen_sel <= klen_in, Nr <= 10/12/14, ptr <= Nr, go to READY.
  - key_commit with klen_in == 11: stay in LOAD, cfg_err pulse.
- State READY: ptr=Nr, rkey_vld=1.
  - next_rkey: ptr <= Nr-1, go to STREAM.
  - wr_en: write takes effect, go to LOAD (key set invalidated).
  - key_commit: re-latch klen, ptr <= new Nr, stay in READY.
- State STREAM: rkey_vld=1.
  - next_rkey with ptr>0: ptr <= ptr-1.
  - next_rkey with ptr==0: ptr <= Nr, go to READY, blk_done pulse, blk_cnt+1.
  - wr_en or key_commit: ignored, cfg_err pulse. The current block is protected.
- key_clear: from any state, next cycle go to LOAD with rkey_vld=0, ptr=0; klen_sel is held. key_clear has priority over next_rkey, wr_en and key_commit in the same cycle.
- Simultaneous wr_en and key_commit in LOAD: the write lands first. The commit sees the new data because rkey is read in a later cycle.
- wr_addr=15: write dropped, cfg_err pulse, no state change.
- Keys per block = Nr+1 (11/13/15), which matches the engine's consume count: one in its idle state plus one per round.
- next_rkey with rkey_vld=0: no effect.
- Reset mid-STREAM: go immediately to LOAD. The host must rewrite or re-commit keys; stored keys remain usable after a re-commit.
- blk_cnt wraps from 0xFFFF to 0x0000.

Test Plan:
- Load rk[i]=i replicated to 128 bits, i=0..10, commit klen=00. Then 11 back-to-back next_rkey → rkey sequence 10,9,...,0; blk_done on the 11th consume; blk_cnt=1; state READY with rkey=rk[10].
- Same flow with klen=10 (15 keys) and klen=01 (13 keys) → first rkey=rk[14] and rk[12] respectively; blk_done after the 15th and 13th consume.
- Commit with klen_in=11 → cfg_err=1 for one cycle, rkey_vld stays 0.
- During STREAM at ptr=5, assert wr_en to slot 3 → cfg_err pulse, slot 3 unchanged, remaining keys 5..0 delivered.
- key_clear together with next_rkey at ptr=7 → rkey_vld=0 next cycle, ptr=0, no blk_done. Re-commit restarts the sequence at rk[Nr].
- Drop rst_n asynchronously mid-block (no clock edge) → rkey_vld=0, blk_cnt=0 immediately. Preset blk_cnt=0xFFFF and complete a block → blk_cnt=0x0000.
